cache_mem_responder: RTL



---
 rtl/cache_mem_responder_if.sv | 29 ++
 rtl/cache_mem_responder.sv | 96 +++++++++
 2 files changed

// File: rtl/cache_mem_responder_if.sv
// Cache-line memory port between the line (master) and the memory
// responder (slave).
//   mem_addr/mem_in/mem_wrreq/mem_rdreq : line -> memory request side
//   mem_out/mem_out_valid              : memory -> line read response
//   mem_pause                          : memory -> line, read queue nearly full
//   mem_overflow                       : memory -> line, sticky dropped-read flag
interface cache_mem_responder_if #(
  parameter int ADDRBITS = 32,
  parameter int DATABITS = 32
);
  logic [ADDRBITS-1:0] mem_addr;
  logic [DATABITS-1:0] mem_in;
  logic                mem_wrreq;
  logic                mem_rdreq;
  logic [DATABITS-1:0] mem_out;
  logic                mem_out_valid;
  logic                mem_pause;
  logic                mem_overflow;

  modport master (
    output mem_addr, mem_in, mem_wrreq, mem_rdreq,
    input  mem_out, mem_out_valid, mem_pause, mem_overflow
  );

  modport slave (
    input  mem_addr, mem_in, mem_wrreq, mem_rdreq,
    output mem_out, mem_out_valid, mem_pause, mem_overflow
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache-line memory port.
// Word-addressed backing array (not reset). Writes land every cycle they are
// requested. Reads are queued in order and issued to the array whenever no
// write owns the single array port; data returns READLAT edges after issue.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset (queue, pipeline, flags)
//   mem     : cache_mem_responder_if.slave (request, response, pause, overflow)
module cache_mem_responder #(
  parameter int ADDRBITS    = 32,
  parameter int DATABITS    = 32,
  parameter int MEMADDRBITS = 10,
  parameter int FIFOBITS    = 3,
  parameter int READLAT     = 2,
  parameter int PAUSEMARGIN = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cache_mem_responder_if.slave  mem
);
  localparam int DEPTH = 2**FIFOBITS;
  localparam logic [FIFOBITS:0] CNT_FULL = (FIFOBITS+1)'(DEPTH);
  localparam logic [FIFOBITS:0] PAUSE_AT = (FIFOBITS+1)'(DEPTH - PAUSEMARGIN);

  typedef logic [MEMADDRBITS-1:0] idx_t;
  typedef logic [DATABITS-1:0]    word_t;

  word_t mem_arr [0:(2**MEMADDRBITS)-1];
  idx_t  fifo_q  [0:DEPTH-1];

  logic [FIFOBITS-1:0] wr_ptr, rd_ptr;
  logic [FIFOBITS:0]   count, count_next;
  logic                empty, full, push, pop, drop;
  idx_t                req_idx;

  logic [READLAT:1]               vld_pipe;
  logic [READLAT:1][DATABITS-1:0] data_pipe;
  logic                           pause_q, overflow_q;

  // Byte address -> word index; low byte bits and upper bits are ignored
  // so higher addresses alias onto the array.
  assign req_idx = mem.mem_addr[MEMADDRBITS+1:2];

  logic unused_addr;
  assign unused_addr = ^mem.mem_addr;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);
  // A write owns the array port, so it blocks issue for that cycle.
  assign pop   = !empty && !mem.mem_wrreq;
  // Full queue still accepts a push when the head leaves on the same edge.
  assign push  = mem.mem_rdreq && (!full || pop);
  assign drop  = mem.mem_rdreq && full && !pop;
  assign count_next = count + {{FIFOBITS{1'b0}}, push} - {{FIFOBITS{1'b0}}, pop};

  // Storage without reset: array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem.mem_wrreq) mem_arr[req_idx] <= mem.mem_in;
    if (push)          fifo_q[wr_ptr]   <= req_idx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      vld_pipe   <= '0;
      data_pipe  <= '0;
      pause_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFOBITS'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFOBITS'(1);
      count <= count_next;

      // Stage 1 is the array read; later stages only advance on a valid beat
      // so the last stage (mem_out) holds between responses.
      vld_pipe[1] <= pop;
      if (pop) data_pipe[1] <= mem_arr[fifo_q[rd_ptr]];
      for (int s = 2; s <= READLAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) data_pipe[s] <= data_pipe[s-1];
      end

      // Registered pause; the line has one request in flight after sampling
      // it, which the PAUSEMARGIN free entries absorb.
      pause_q <= (count_next >= PAUSE_AT);
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign mem.mem_out       = data_pipe[READLAT];
  assign mem.mem_out_valid = vld_pipe[READLAT];
  assign mem.mem_pause     = pause_q;
  assign mem.mem_overflow  = overflow_q;
endmodule
